mc_controller: RTL and testbench

MC_CONTROLLER -- requirements
Module: mc_controller

---
 rtl/mc_ctrl_pkg.sv | 64 ++++++
 rtl/mc_ctrl_decode.sv | 36 +++
 rtl/mc_controller.sv | 219 +++++++++++++++++++++
 tb/tb_mc_controller.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle controller.
// States, opcode/func constants, mux selects and trap codes.
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_e;

    typedef enum logic [3:0] {
        K_ILLEGAL,
        K_J,
        K_JR,
        K_JAL,
        K_BEQ,
        K_BNE,
        K_ADDI,
        K_ADD,
        K_SUB,
        K_LW,
        K_SW
    } kind_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_JR  = 6'b001000;
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;

    localparam logic [1:0] PC_S_PC4 = 2'b00;
    localparam logic [1:0] PC_S_RS  = 2'b01;
    localparam logic [1:0] PC_S_BR  = 2'b10;
    localparam logic [1:0] PC_S_JMP = 2'b11;

    localparam logic [1:0] WR_S_RD = 2'b00;
    localparam logic [1:0] WR_S_RT = 2'b01;
    localparam logic [1:0] WR_S_RA = 2'b11;

    localparam logic [1:0] WD_S_ALU = 2'b00;
    localparam logic [1:0] WD_S_MEM = 2'b01;
    localparam logic [1:0] WD_S_PC4 = 2'b10;

    localparam logic [1:0] TC_NONE    = 2'b00;
    localparam logic [1:0] TC_ILLEGAL = 2'b01;
    localparam logic [1:0] TC_TIMEOUT = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;

    // Wide enough for the largest allowed memory timeout (255).
    localparam int CNT_W = 8;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Instruction classifier for the multi-cycle controller.
// Load/store kinds exist only when MC_CTRL_LDST_EN is defined.
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] func,
    output kind_e      kind
);

    // Map op/func onto one instruction kind; anything unknown is illegal.
    always_comb begin
        kind = K_ILLEGAL;
        case (op)
            OP_RTYPE: begin
                case (func)
                    FN_JR:   kind = K_JR;
                    FN_ADD:  kind = K_ADD;
                    FN_SUB:  kind = K_SUB;
                    default: kind = K_ILLEGAL;
                endcase
            end
            OP_J:    kind = K_J;
            OP_JAL:  kind = K_JAL;
            OP_BEQ:  kind = K_BEQ;
            OP_BNE:  kind = K_BNE;
            OP_ADDI: kind = K_ADDI;
`ifdef MC_CTRL_LDST_EN
            OP_LW:   kind = K_LW;
            OP_SW:   kind = K_SW;
`endif
            default: kind = K_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle control FSM with memory wait timeout and sticky trap.
// Define MC_CTRL_LDST_EN to add lw/sw through the MEM state.
module mc_controller
    import mc_ctrl_pkg::*;
#(
    parameter int ALU_OP_W    = 3,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [5:0]          op,
    input  logic [5:0]          func,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                mem_write,
    output logic                ir_write,
    output logic                pc_write,
    output logic [1:0]          pc_s,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                imm_s,
    output logic [1:0]          w_r_s,
    output logic [1:0]          wr_data_s,
    output logic                write_reg,
    output logic [2:0]          state,
    output logic [1:0]          trap_cause
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [5:0]       op_q, op_d;
    logic [5:0]       func_q, func_d;
    logic [1:0]       trap_q, trap_d;

    logic [5:0] dec_op;
    logic [5:0] dec_func;
    kind_e      kind;
    logic [2:0] alu3;
    logic       tmo_hit;

    // DECODE sees the live fields; later states use the latched copy.
    assign dec_op   = (state_q == S_DECODE) ? op   : op_q;
    assign dec_func = (state_q == S_DECODE) ? func : func_q;

    mc_ctrl_decode u_decode (
        .op   (dec_op),
        .func (dec_func),
        .kind (kind)
    );

    assign tmo_hit    = (cnt_q == CNT_W'(MEM_TIMEOUT));
    assign state      = state_q;
    assign trap_cause = trap_q;
    assign alu_op     = ALU_OP_W'(alu3);

    // State, wait counter, latched instruction and trap cause.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
            op_q    <= '0;
            func_q  <= '0;
            trap_q  <= TC_NONE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            func_q  <= func_d;
            trap_q  <= trap_d;
        end
    end

    // Next state; the counter is zero outside FETCH/MEM so entry clears it.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        op_d    = op_q;
        func_d  = func_q;
        trap_d  = trap_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) begin
                    state_d = S_DECODE;
                end else if (tmo_hit) begin
                    state_d = S_TRAP;
                    trap_d  = TC_TIMEOUT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DECODE: begin
                op_d   = op;
                func_d = func;
                case (kind)
                    K_J, K_JR, K_JAL: state_d = S_FETCH;
                    K_BEQ, K_BNE:     state_d = S_EXEC;
                    K_ADDI:           state_d = S_EXEC;
                    K_ADD, K_SUB:     state_d = S_EXEC;
`ifdef MC_CTRL_LDST_EN
                    K_LW, K_SW:       state_d = S_EXEC;
`endif
                    default: begin
                        state_d = S_TRAP;
                        trap_d  = TC_ILLEGAL;
                    end
                endcase
            end
            S_EXEC: begin
                case (kind)
                    K_BEQ, K_BNE: state_d = S_FETCH;
`ifdef MC_CTRL_LDST_EN
                    K_LW, K_SW:   state_d = S_MEM;
`endif
                    default:      state_d = S_WB;
                endcase
            end
`ifdef MC_CTRL_LDST_EN
            S_MEM: begin
                if (mem_ready) begin
                    state_d = (kind == K_SW) ? S_FETCH : S_WB;
                end else if (tmo_hit) begin
                    state_d = S_TRAP;
                    trap_d  = TC_TIMEOUT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            S_WB:    state_d = S_FETCH;
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase
    end

    // Control outputs; the fetch handshake is masked while in reset.
    always_comb begin
        mem_req   = 1'b0;
        mem_write = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        pc_s      = PC_S_PC4;
        alu3      = ALU_ADD;
        imm_s     = 1'b0;
        w_r_s     = WR_S_RD;
        wr_data_s = WD_S_ALU;
        write_reg = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready && rst_n) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    pc_s     = PC_S_PC4;
                end
            end
            S_DECODE: begin
                case (kind)
                    K_J: begin
                        pc_write = 1'b1;
                        pc_s     = PC_S_JMP;
                    end
                    K_JR: begin
                        pc_write = 1'b1;
                        pc_s     = PC_S_RS;
                    end
                    K_JAL: begin
                        pc_write  = 1'b1;
                        pc_s      = PC_S_JMP;
                        write_reg = 1'b1;
                        w_r_s     = WR_S_RA;
                        wr_data_s = WD_S_PC4;
                    end
                    default: ;
                endcase
            end
            S_EXEC: begin
                case (kind)
                    K_BEQ: begin
                        alu3     = ALU_SUB;
                        pc_write = zero;
                        pc_s     = PC_S_BR;
                    end
                    K_BNE: begin
                        alu3     = ALU_SUB;
                        pc_write = !zero;
                        pc_s     = PC_S_BR;
                    end
                    K_ADDI: imm_s = 1'b1;
                    K_SUB:  alu3  = ALU_SUB;
`ifdef MC_CTRL_LDST_EN
                    K_LW, K_SW: imm_s = 1'b1;
`endif
                    default: ;
                endcase
            end
`ifdef MC_CTRL_LDST_EN
            S_MEM: begin
                mem_req   = 1'b1;
                mem_write = (kind == K_SW);
            end
`endif
            S_WB: begin
                write_reg = 1'b1;
                case (kind)
                    K_ADDI: w_r_s = WR_S_RT;
`ifdef MC_CTRL_LDST_EN
                    K_LW: begin
                        w_r_s     = WR_S_RT;
                        wr_data_s = WD_S_MEM;
                    end
`endif
                    default: w_r_s = WR_S_RD;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller (MEM_TIMEOUT=4, ALU_OP_W=4).
// Covers lw/sw through MEM when MC_CTRL_LDST_EN is defined.
module tb_mc_controller;

    logic       clk;
    logic       rst_n;
    logic [5:0] op;
    logic [5:0] func;
    logic       zero;
    logic       mem_ready;
    logic       mem_req;
    logic       mem_write;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_s;
    logic [3:0] alu_op;
    logic       imm_s;
    logic [1:0] w_r_s;
    logic [1:0] wr_data_s;
    logic       write_reg;
    logic [2:0] state;
    logic [1:0] trap_cause;

    logic [15:0] ctl;
    int total;
    int bad;

    mc_controller #(
        .ALU_OP_W    (4),
        .MEM_TIMEOUT (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op         (op),
        .func       (func),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .pc_s       (pc_s),
        .alu_op     (alu_op),
        .imm_s      (imm_s),
        .w_r_s      (w_r_s),
        .wr_data_s  (wr_data_s),
        .write_reg  (write_reg),
        .state      (state),
        .trap_cause (trap_cause)
    );

    assign ctl = {mem_req, mem_write, ir_write, pc_write, pc_s,
                  alu_op, imm_s, w_r_s, wr_data_s, write_reg};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] e(
        input logic       mr,  input logic       mw,
        input logic       irw, input logic       pcw,
        input logic [1:0] pcs, input logic [3:0] alu,
        input logic       imm, input logic [1:0] wrs,
        input logic [1:0] wds, input logic       wr
    );
        return {mr, mw, irw, pcw, pcs, alu, imm, wrs, wds, wr};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s got=%h want=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_state", 16'(state), 16'd0);
        chk("rst_ctl", ctl, e(1,0,0,0,2'b00,4'd0,0,2'b00,2'b00,0));
        chk("rst_tc", 16'(trap_cause), 16'd0);
        step();
        rst_n = 1'b1;
    endtask

    task automatic fetch_ins(input logic [5:0] o, input logic [5:0] f);
        mem_ready = 1'b1;
        #1;
        chk("fetch_state", 16'(state), 16'd0);
        chk("fetch_ctl", ctl, e(1,0,1,1,2'b00,4'd0,0,2'b00,2'b00,0));
        step();
        mem_ready = 1'b0;
        op   = o;
        func = f;
        #1;
        chk("dec_state", 16'(state), 16'd1);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        op        = 6'd0;
        func      = 6'd0;
        zero      = 1'b0;
        mem_ready = 1'b1;
        #12;
        // handshake must stay masked while reset is held
        chk("rst_hold_ctl", ctl, e(1,0,0,0,2'b00,4'd0,0,2'b00,2'b00,0));
        mem_ready = 1'b0;
        do_reset();

        // addi: 0,1,2,4,0
        fetch_ins(6'b001000, 6'd0);
        chk("addi_dec", ctl, 16'd0);
        step();
        chk("addi_ex_st", 16'(state), 16'd2);
        chk("addi_ex", ctl, e(0,0,0,0,2'b00,4'd0,1,2'b00,2'b00,0));
        step();
        chk("addi_wb_st", 16'(state), 16'd4);
        chk("addi_wb", ctl, e(0,0,0,0,2'b00,4'd0,0,2'b01,2'b00,1));
        step();
        chk("addi_end_st", 16'(state), 16'd0);
        chk("addi_end", ctl, e(1,0,0,0,2'b00,4'd0,0,2'b00,2'b00,0));

        // beq: pc_write follows zero within EXEC
        fetch_ins(6'b000100, 6'd0);
        step();
        zero = 1'b1;
        #1;
        chk("beq_z1", ctl, e(0,0,0,1,2'b10,4'd1,0,2'b00,2'b00,0));
        zero = 1'b0;
        #1;
        chk("beq_z0", ctl, e(0,0,0,0,2'b10,4'd1,0,2'b00,2'b00,0));
        step();
        chk("beq_end", 16'(state), 16'd0);

        // bne: inverse
        fetch_ins(6'b000101, 6'd0);
        step();
        zero = 1'b1;
        #1;
        chk("bne_z1", ctl, e(0,0,0,0,2'b10,4'd1,0,2'b00,2'b00,0));
        zero = 1'b0;
        #1;
        chk("bne_z0", ctl, e(0,0,0,1,2'b10,4'd1,0,2'b00,2'b00,0));
        step();
        chk("bne_end", 16'(state), 16'd0);

        // jal
        fetch_ins(6'b000011, 6'd0);
        chk("jal_dec", ctl, e(0,0,0,1,2'b11,4'd0,0,2'b11,2'b10,1));
        step();
        chk("jal_end", 16'(state), 16'd0);

        // jr
        fetch_ins(6'b000000, 6'b001000);
        chk("jr_dec", ctl, e(0,0,0,1,2'b01,4'd0,0,2'b00,2'b00,0));
        step();
        chk("jr_end", 16'(state), 16'd0);

        // R-sub
        fetch_ins(6'b000000, 6'b100010);
        chk("sub_dec", ctl, 16'd0);
        step();
        chk("sub_ex", ctl, e(0,0,0,0,2'b00,4'd1,0,2'b00,2'b00,0));
        step();
        chk("sub_wb_st", 16'(state), 16'd4);
        chk("sub_wb", ctl, e(0,0,0,0,2'b00,4'd0,0,2'b00,2'b00,1));
        step();
        chk("sub_end", 16'(state), 16'd0);

        // R-add
        fetch_ins(6'b000000, 6'b100000);
        step();
        chk("add_ex", ctl, e(0,0,0,0,2'b00,4'd0,0,2'b00,2'b00,0));
        step();
        chk("add_wb", ctl, e(0,0,0,0,2'b00,4'd0,0,2'b00,2'b00,1));
        step();

        // illegal opcode -> sticky trap
        fetch_ins(6'b111111, 6'd0);
        chk("ill_dec", ctl, 16'd0);
        step();
        mem_ready = 1'b1;
        zero = 1'b1;
        for (int i = 0; i < 20; i++) begin
            chk("trap_st", 16'(state), 16'd5);
            chk("trap_tc", 16'(trap_cause), 16'd1);
            chk("trap_ctl", ctl, 16'd0);
            step();
        end
        zero = 1'b0;
        mem_ready = 1'b0;
        do_reset();
        chk("post_trap", 16'(state), 16'd0);

        // fetch timeout: counter hits 4 with no ready
        step(4);
        chk("tmo_edge_st", 16'(state), 16'd0);
        step();
        chk("tmo_st", 16'(state), 16'd5);
        chk("tmo_tc", 16'(trap_cause), 16'd2);
        chk("tmo_ctl", ctl, 16'd0);
        do_reset();

        // ready on the boundary cycle wins
        step(4);
        mem_ready = 1'b1;
        #1;
        chk("bnd_ctl", ctl, e(1,0,1,1,2'b00,4'd0,0,2'b00,2'b00,0));
        step();
        mem_ready = 1'b0;
        op = 6'b000010;
        #1;
        chk("bnd_st", 16'(state), 16'd1);
        chk("bnd_tc", 16'(trap_cause), 16'd0);
        chk("j_dec", ctl, e(0,0,0,1,2'b11,4'd0,0,2'b00,2'b00,0));
        step();
        chk("j_end", 16'(state), 16'd0);

        // reset mid-instruction leaves no write pulse
        fetch_ins(6'b001000, 6'd0);
        step();
        rst_n = 1'b0;
        #1;
        chk("mid_st", 16'(state), 16'd0);
        chk("mid_ctl", ctl, e(1,0,0,0,2'b00,4'd0,0,2'b00,2'b00,0));
        step(2);
        chk("mid_hold", ctl, e(1,0,0,0,2'b00,4'd0,0,2'b00,2'b00,0));
        rst_n = 1'b1;

`ifdef MC_CTRL_LDST_EN
        // sw: MEM held 3 cycles, ready on the third
        fetch_ins(6'b101011, 6'd0);
        step();
        chk("sw_ex", ctl, e(0,0,0,0,2'b00,4'd0,1,2'b00,2'b00,0));
        step();
        chk("sw_mem1_st", 16'(state), 16'd3);
        chk("sw_mem1", ctl, e(1,1,0,0,2'b00,4'd0,0,2'b00,2'b00,0));
        step();
        chk("sw_mem2", ctl, e(1,1,0,0,2'b00,4'd0,0,2'b00,2'b00,0));
        step();
        mem_ready = 1'b1;
        #1;
        chk("sw_mem3_st", 16'(state), 16'd3);
        chk("sw_mem3", ctl, e(1,1,0,0,2'b00,4'd0,0,2'b00,2'b00,0));
        step();
        mem_ready = 1'b0;
        #1;
        chk("sw_end", 16'(state), 16'd0);

        // lw: MEM then WB from memory into rt
        fetch_ins(6'b100011, 6'd0);
        step();
        step();
        mem_ready = 1'b1;
        #1;
        chk("lw_mem", ctl, e(1,0,0,0,2'b00,4'd0,0,2'b00,2'b00,0));
        step();
        mem_ready = 1'b0;
        #1;
        chk("lw_wb_st", 16'(state), 16'd4);
        chk("lw_wb", ctl, e(0,0,0,0,2'b00,4'd0,0,2'b01,2'b01,1));
        step();
`else
        // lw is illegal without load/store support
        fetch_ins(6'b100011, 6'd0);
        step();
        chk("lw_trap_st", 16'(state), 16'd5);
        chk("lw_trap_tc", 16'(trap_cause), 16'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
